// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencer for a small 16-bit datapath.
// Ports: clock/reset (sync, active-high), start pulse, instruction
// fetch (instr_addr out, instr_data in one cycle later), datapath
// flags in, register-file/ALU controls out, halted/illegal status.
module control_unit #(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [15:0]     instr_data,
  input  logic            zero_flag,
  input  logic            pos_flag,
  output logic            rf_write,
  output logic [2:0]      rs_addr,
  output logic [2:0]      rt_addr,
  output logic [2:0]      rd_addr,
  output logic [15:0]     imm_data,
  output logic [3:0]      alu_sel,
  output logic            imm_sel,
  output logic            mem_write,
  output logic            halted,
  output logic            illegal
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] EXECUTE = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_BEQZ = 4'h3;
  localparam logic [3:0] OP_BGTZ = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  logic [3:0]  op;
  logic [15:0] imm_ext;
  logic        br_take;

  assign op      = ir[15:12];
  assign imm_ext = {{10{ir[5]}}, ir[5:0]};

  // Branch condition sampled from the live flags while in EXECUTE.
  always_comb begin
    br_take = 1'b0;
    if (op == OP_BEQZ) br_take = zero_flag;
    if (op == OP_BGTZ) br_take = pos_flag && !zero_flag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (start) state <= FETCH;
        FETCH:  state <= DECODE;
        DECODE: begin
          ir    <= instr_data;
          pc    <= pc + 1'b1;
          state <= EXECUTE;
        end
        EXECUTE: begin
          state <= FETCH;
          case (op)
            OP_NOP, OP_ALU, OP_ADDI: ;
            // pc already points past the branch here
            OP_BEQZ, OP_BGTZ:
              if (br_take) pc <= pc + imm_ext[PC_W-1:0];
            OP_JMP:  pc <= ir[PC_W-1:0];
            OP_HALT: state <= HALT;
            default: begin
              state   <= HALT;
              illegal <= 1'b1;
            end
          endcase
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_addr = pc;
  assign halted     = (state == HALT);
  assign mem_write  = 1'b0;

  always_comb begin
    rf_write = 1'b0;
    rs_addr  = 3'd0;
    rt_addr  = 3'd0;
    rd_addr  = 3'd0;
    imm_data = 16'd0;
    alu_sel  = 4'd0;
    imm_sel  = 1'b0;
    if (state == EXECUTE) begin
      case (op)
        OP_ALU: begin
          rs_addr  = ir[8:6];
          rt_addr  = ir[5:3];
          rd_addr  = ir[11:9];
          alu_sel  = {1'b0, ir[2:0]};
          rf_write = 1'b1;
        end
        OP_ADDI: begin
          rs_addr  = ir[8:6];
          rd_addr  = ir[11:9];
          imm_data = imm_ext;
          imm_sel  = 1'b1;
          rf_write = 1'b1;
        end
        // compare rs against zero through the ALU
        OP_BEQZ, OP_BGTZ: begin
          rs_addr = ir[8:6];
          imm_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Registered instruction memory model feeds instr_data one cycle later.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data = 16'd0;
  logic        zero_flag = 1'b0;
  logic        pos_flag = 1'b0;
  logic        rf_write;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        imm_sel, mem_write, halted, illegal;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  control_unit #(.PC_W(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .zero_flag(zero_flag), .pos_flag(pos_flag),
    .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .imm_data(imm_data), .alu_sel(alu_sel),
    .imm_sel(imm_sel), .mem_write(mem_write),
    .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) instr_data <= mem[instr_addr];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1298; // ALU rd=1 rs=2 rt=3 func=0
    mem[8'h01] = 16'h297F; // ADDI rd=4 rs=5 imm=-1
    mem[8'h02] = 16'h5010; // JMP 0x10
    mem[8'h10] = 16'h307C; // BEQZ rs=1 imm=-4
    mem[8'h0D] = 16'h5010; // JMP 0x10
    mem[8'h11] = 16'h4045; // BGTZ rs=1 imm=5
    mem[8'h12] = 16'h50FF; // JMP 0xFF
    mem[8'hFF] = 16'h0000; // NOP

    tick(2);
    reset = 1'b0;
    chk("rst_addr", instr_addr, 0);
    chk("rst_rfw", rf_write, 0);
    chk("rst_ctl", {rs_addr, rt_addr, rd_addr, alu_sel, imm_sel}, 0);
    chk("rst_imm", imm_data, 0);
    chk("rst_halt", {halted, illegal, mem_write}, 0);

    tick(2);
    chk("idle_hold", {instr_addr, rf_write, halted}, 0);

    pulse_start();
    chk("c1_fetch", instr_addr, 8'h00);
    chk("c1_rfw", rf_write, 0);
    tick(2);
    chk("alu_rfw", rf_write, 1);
    chk("alu_regs", {rd_addr, rs_addr, rt_addr}, {3'd1, 3'd2, 3'd3});
    chk("alu_sel", {alu_sel, imm_sel}, 5'b0);
    chk("alu_pc", instr_addr, 8'h01);
    tick();
    chk("alu_rfw_off", rf_write, 0);

    tick(2);
    chk("addi_rfw", rf_write, 1);
    chk("addi_imm", imm_data, 16'hFFFF);
    chk("addi_isel", imm_sel, 1);
    chk("addi_regs", {rd_addr, rs_addr, alu_sel}, {3'd4, 3'd5, 4'd0});
    tick();
    chk("addi_rfw_off", rf_write, 0);
    chk("addi_next", instr_addr, 8'h02);

    tick(3);
    chk("jmp_fetch", instr_addr, 8'h10);
    zero_flag = 1'b1;
    tick(2);
    chk("beqz_ctl", {rf_write, rs_addr, imm_sel}, {1'b0, 3'd1, 1'b1});
    chk("beqz_imm", {imm_data, alu_sel}, 0);
    tick();
    chk("beqz_taken", instr_addr, 8'h0D);

    tick(3);
    chk("jmp_back", instr_addr, 8'h10);
    zero_flag = 1'b0;
    tick(3);
    chk("beqz_nt", instr_addr, 8'h11);

    pos_flag = 1'b1;
    zero_flag = 1'b1;
    tick(2);
    chk("bgtz_rfw", rf_write, 0);
    tick();
    chk("bgtz_nt", instr_addr, 8'h12);
    pos_flag = 1'b0;
    zero_flag = 1'b0;

    tick(3);
    chk("jmp_ff", instr_addr, 8'hFF);
    tick(2);
    chk("nop_rfw", rf_write, 0);
    tick();
    chk("nop_wrap", instr_addr, 8'h00);

    tick(2);
    chk("alu2_rfw", rf_write, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_ex_rfw", rf_write, 0);
    chk("rst_ex_addr", instr_addr, 0);
    chk("rst_ex_ctl", {rd_addr, rs_addr, rt_addr}, 0);
    tick(4);
    chk("rst_ex_idle", {instr_addr, rf_write, halted}, 0);

    mem[8'h00] = 16'h7000;
    pulse_start();
    tick(2);
    chk("ill_rfw", rf_write, 0);
    tick();
    chk("ill_halt", {halted, illegal}, 2'b11);
    chk("ill_pc", instr_addr, 8'h01);
    pulse_start();
    tick(3);
    chk("halt_start", {halted, illegal, instr_addr}, {2'b11, 8'h01});
    chk("halt_rfw", rf_write, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("halt_rst", {halted, illegal, instr_addr}, 0);

    mem[8'h00] = 16'hF000;
    tick();
    pulse_start();
    tick(3);
    chk("hlt_op", {halted, illegal}, 2'b10);
    chk("mem_write", mem_write, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, meaning the program counter and instruction address width.
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  single-cycle pulse that begins execution from IDLE.
REQ-005 The block SHALL have port instr_addr  output  PC_W  instruction memory address.
REQ-006 The block SHALL have port instr_data  input  16  instruction word, valid one cycle after instr_addr.
REQ-007 The block SHALL have port zero_flag  input  1  datapath zero flag.
REQ-008 The block SHALL have port pos_flag  input  1  datapath positive flag.
REQ-009 The block SHALL have ports rf_write (1), rs_addr (3), rt_addr (3), rd_addr (3), imm_data (16), alu_sel (4), imm_sel (1) and mem_write (1), all outputs driving the same-named datapath inputs.
REQ-010 The block SHALL have port halted  output  1  high in HALT state.
REQ-011 The block SHALL have port illegal  output  1  sticky flag for an illegal-opcode halt.

Function
REQ-012 Instruction fields SHALL be: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], func=[2:0], imm6=[5:0], target=[PC_W-1:0].
REQ-013 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE and HALT.
REQ-014 IDLE SHALL go to FETCH on start=1 and otherwise stay in IDLE.
REQ-015 FSM sequencing SHALL be: FETCH to DECODE to EXECUTE, then back to FETCH, with 3 cycles per instruction.
REQ-016 In FETCH, instr_addr SHALL equal pc; in all other states instr_addr SHALL hold pc.
REQ-017 In DECODE, IR SHALL be loaded from instr_data and pc SHALL be set to pc+1 modulo 2^PC_W (0xFF wraps to 0x00).
REQ-018 In EXECUTE, op 0x0 (NOP) SHALL drive no writes.
REQ-019 In EXECUTE, op 0x1 (ALU) SHALL drive rs_addr=rs, rt_addr=rt, rd_addr=rd, imm_sel=0, alu_sel={0,func} and rf_write=1.
REQ-020 In EXECUTE, op 0x2 (ADDI) SHALL drive rs_addr=rs, rd_addr=rd, imm_data=sign-extended imm6, imm_sel=1, alu_sel=4'b0000 (ADD) and rf_write=1.
REQ-021 In EXECUTE, op 0x3 (BEQZ) SHALL drive rs_addr=rs, imm_sel=1, imm_data=0, alu_sel=ADD and rf_write=0; if zero_flag=1, pc SHALL become pc+sext(imm6) modulo 2^PC_W, using the already-incremented pc.
REQ-022 In EXECUTE, op 0x4 (BGTZ) SHALL drive the same controls as BEQZ and SHALL take the branch only when pos_flag=1 and zero_flag=0.
REQ-023 In EXECUTE, op 0x5 (JMP) SHALL set pc to target.
REQ-024 In EXECUTE, op 0xF (HALT) SHALL move to HALT with illegal=0.
REQ-025 In EXECUTE, ops 0x6 to 0xE SHALL move to HALT with illegal=1 and SHALL NOT assert rf_write.
REQ-026 Flags SHALL be sampled combinationally in EXECUTE, in the same cycle the controls are driven.
REQ-027 rf_write SHALL be high for exactly one cycle per ALU or ADDI instruction and SHALL NOT be high in any other cycle.
REQ-028 mem_write SHALL be constant 0.
REQ-029 Outside EXECUTE, rf_write, rs_addr, rt_addr, rd_addr, imm_data, alu_sel and imm_sel SHALL all be 0.
REQ-030 Control outputs SHALL be combinational from state and IR; pc, IR, state and illegal SHALL be registered.
REQ-031 HALT SHALL be absorbing until reset; start SHALL be ignored in HALT.
REQ-032 start SHALL be ignored in any state other than IDLE.

Reset
REQ-033 When reset=1 at a clock edge, the block SHALL set state=IDLE, pc=0, IR=0, illegal=0 and halted=0, with reset taking priority over start.
REQ-034 After reset, all control outputs SHALL be 0; a reset applied in EXECUTE SHALL leave no rf_write high in the following cycle.

Verification
REQ-035 The bench SHALL cover: reset then start, with mem[0]=0x1000|rd=1,rs=2,rt=3,func=0 -> instr_addr=0 at cycle 1, rf_write=1 with rd_addr=1, rs_addr=2, rt_addr=3, alu_sel=0 in cycle 3, pc=1.
REQ-036 The bench SHALL cover: ADDI with imm6=0x3F -> imm_data=0xFFFF, imm_sel=1, rf_write=1 for one cycle.
REQ-037 The bench SHALL cover: BEQZ at pc=0x10 with imm6=0x3C (-4) and zero_flag=1 -> next fetch address 0x0D; the same case with zero_flag=0 -> next fetch address 0x11.
REQ-038 The bench SHALL cover: BGTZ with pos_flag=1 and zero_flag=1 -> not taken; JMP target=0xFF then NOP -> next fetch addresses 0xFF then 0x00 (wrap).
REQ-039 The bench SHALL cover: op 0x7 -> halted=1, illegal=1, no rf_write; then a start pulse -> no change; then reset -> IDLE with pc=0 and illegal=0.
REQ-040 The bench SHALL cover: reset asserted during EXECUTE of an ALU instruction -> state=IDLE and rf_write=0 on the next cycle.
